seven_seg_mux: RTL and testbench

SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

---
 rtl/seven_seg_mux.sv | 182 ++++++++++++++++++
 tb/tb_seven_seg_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: multiplexed 7-segment driver with binary-to-BCD conversion.
// Ports: clk, rst_n (sync, active-low); load/data capture a value;
//   busy high during decimal conversion; seg (active-low, seg[0]=a);
//   an (active-low digit enables, an[0]=LSD).
// Option: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  localparam int NEED  = (HEX_MODE != 0) ? (DATA_W + 3) / 4
                                         : dec_digits(DATA_W);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 ||
      DATA_W < 1 || DATA_W > 26 ||
      REFRESH_DIV < 2 || NEED > NUM_DIGITS) begin : g_bad_cfg
    $error("seven_seg_mux: illegal configuration");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] bin, bin_nxt;
  logic [BCD_W-1:0]  bcd, bcd_adj, bcd_nxt;
  logic [BCD_W-1:0]  disp, data_ext;
  logic [CNT_W-1:0]  cnt;
  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cur;
  logic              last;
  logic              blank;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign busy     = (state == CONV);
  assign last     = (cnt == CNT_W'(DATA_W - 1));
  assign data_ext = BCD_W'(data);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load && HEX_MODE == 0) state_nxt = CONV;
      CONV: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // one double-dabble step: add 3 to digits >= 5, then shift left
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj[BCD_W-2:0], bin, 1'b0};
  end

  // disp only changes on commit so partial BCD is never shown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      disp <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        if (HEX_MODE != 0) begin
          disp <= data_ext;
        end else begin
          bin <= data;
          bcd <= '0;
          cnt <= '0;
        end
      end
    end else begin
      bin <= bin_nxt;
      bcd <= bcd_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) disp <= bcd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      if (idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
      else                               idx <= idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) cur = disp[4*i +: 4];
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // blank a digit when it and every digit above it are zero
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz = nz | (disp[4*i +: 4] != 4'd0);
      if (IDX_W'(i) == idx && !nz) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 7'b1111111;
      an  <= '1;
    end else begin
      seg <= blank ? 7'b1111111 : hex7(cur);
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed checks of seven_seg_mux
// (decimal instance and hex instance, 4 digits, 8-bit data, refresh 4).
module tb_seven_seg_mux;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, load, hx_load;
  logic [7:0] data, hx_data;
  logic       busy, hx_busy;
  logic [6:0] seg, hx_seg;
  logic [3:0] an, hx_an;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seven_seg_mux #(
    .NUM_DIGITS(4), .DATA_W(8), .REFRESH_DIV(4), .HEX_MODE(0)
  ) u_dec (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .busy(busy), .seg(seg), .an(an)
  );

  seven_seg_mux #(
    .NUM_DIGITS(4), .DATA_W(8), .REFRESH_DIV(4), .HEX_MODE(1)
  ) u_hex (
    .clk(clk), .rst_n(rst_n), .load(hx_load), .data(hx_data),
    .busy(hx_busy), .seg(hx_seg), .an(hx_an)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic scan(input bit hx, input logic [3:0] an_exp,
                      input logic [6:0] seg_exp, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((hx ? hx_an : an) === an_exp) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) chk(tag, 32'(hx ? hx_seg : seg), 32'(seg_exp));
  endtask

  initial begin
    int n;
    int k_idx;
    bit fell;
    rst_n   = 1'b0;
    load    = 1'b0;
    data    = '0;
    hx_load = 1'b0;
    hx_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(seg), 32'(BL));
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hx_an", 32'(hx_an), 32'hF);
    chk("rst_hx_busy", 32'(hx_busy), 32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      k_idx = ((k - 1) / 4) % 4;
      chk($sformatf("refresh_an_%0d", k), 32'(an),
          32'(~(4'b0001 << k_idx) & 4'hF));
      if (k == 1) chk("refresh_seg0", 32'(seg), 32'(S0));
    end

    data = 8'd255;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_after_load", 32'(busy), 32'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_cycles_255", 32'(n), 32'd8);
    @(posedge clk);
    scan(1'b0, 4'b1110, S5, "d255_0");
    scan(1'b0, 4'b1101, S5, "d255_1");
    scan(1'b0, 4'b1011, S2, "d255_2");
    scan(1'b0, 4'b0111, LZ, "d255_3");

    data = 8'd123;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    data = 8'd45;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_during_conv", 32'(busy), 32'd1);
    fell = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk);
      if (!busy) fell = 1'b1;
    end
    chk("busy_fell_123", 32'(fell), 32'd1);
    @(posedge clk);
    scan(1'b0, 4'b1110, S3, "d123_0");
    scan(1'b0, 4'b1101, S2, "d123_1");
    scan(1'b0, 4'b1011, S1, "d123_2");
    scan(1'b0, 4'b0111, LZ, "d123_3");

    hx_data = 8'hAB;
    hx_load = 1'b1;
    @(negedge clk);
    hx_load = 1'b0;
    chk("hx_busy_load", 32'(hx_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hx_busy_%0d", i), 32'(hx_busy), 32'd0);
    end
    scan(1'b1, 4'b1110, SB, "hAB_0");
    scan(1'b1, 4'b1101, SA, "hAB_1");
    scan(1'b1, 4'b1011, LZ, "hAB_2");
    scan(1'b1, 4'b0111, LZ, "hAB_3");

    data = 8'd200;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_seg", 32'(seg), 32'(BL));
    chk("abort_an", 32'(an), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_an", 32'(an), 32'hE);
    scan(1'b0, 4'b1110, S0, "abort_0");
    scan(1'b0, 4'b1101, LZ, "abort_1");
    scan(1'b0, 4'b1011, LZ, "abort_2");
    scan(1'b0, 4'b0111, LZ, "abort_3");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
